// File: rtl/timer_0_scheduler.sv
// Shares one 64-bit interval timer (16-bit Avalon-MM slave) among N_REQ one-shot delay requesters.
// Round-robin grant, program period, start one-shot with IRQ, confirm timeout, clear, pulse done.
module timer_0_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DELAY_W = 32,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DELAY_W-1:0] delay,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [ID_W-1:0]          active_id,
  output logic [3:0]               tm_address,
  output logic                     tm_chipselect,
  output logic                     tm_write_n,
  output logic [15:0]              tm_writedata,
  input  logic [15:0]              tm_readdata,
  input  logic                     tm_irq
);

  localparam logic [15:0] CTRL_STOP  = 16'h0008;
  localparam logic [15:0] CTRL_START = 16'h0005;

  typedef enum logic [3:0] {
    INIT, IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_CTRL, WAIT_IRQ,
    RD_STAT, RD_WAIT, CLR_STAT, DONE, ABORT, ABORT_CLR
  } state_t;

  state_t             state_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [63:0]        period_r;
  logic               grant_found_s;
  logic [ID_W-1:0]    grant_id_s;
  logic [ID_W-1:0]    next_ptr_s;
  logic [DELAY_W-1:0] grant_delay_s;
  logic [DELAY_W-1:0] grant_p_s;

  // Round-robin pick of the first pending request at or after the pointer, plus its clamped period
  always_comb begin
    int idx;
    idx           = 0;
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_r) + k) % N_REQ;
      if (!grant_found_s && req[idx]) begin
        grant_found_s = 1'b1;
        grant_id_s    = ID_W'(idx);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    grant_delay_s = delay[int'(grant_id_s)*DELAY_W +: DELAY_W];
    // delay 0/1 would program period 0, so clamp to a 2-clock delay
    if (grant_delay_s < DELAY_W'(2)) begin
      grant_p_s = DELAY_W'(1);
    end else begin
      grant_p_s = grant_delay_s - DELAY_W'(1);
    end
    if (active_id == ID_W'(N_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = active_id + ID_W'(1);
    end
  end

  // Sequencer: bus outputs are registered on entry so each state's bus cycle coincides with the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= INIT;
      done          <= '0;
      busy          <= 1'b1;
      active_id     <= '0;
      rr_ptr_r      <= '0;
      period_r      <= 64'd0;
      tm_chipselect <= 1'b0;
      tm_write_n    <= 1'b1;
      tm_address    <= 4'd0;
      tm_writedata  <= 16'h0000;
    end else begin
      done          <= '0;
      busy          <= 1'b1;
      tm_chipselect <= 1'b0;
      tm_write_n    <= 1'b1;
      tm_address    <= 4'd0;
      tm_writedata  <= 16'h0000;
      case (state_r)
        INIT: begin
          tm_chipselect <= 1'b1;
          tm_write_n    <= 1'b0;
          tm_address    <= 4'd1;
          tm_writedata  <= CTRL_STOP;
          busy          <= 1'b0;
          state_r       <= IDLE;
        end
        IDLE: begin
          if (grant_found_s) begin
            active_id     <= grant_id_s;
            period_r      <= 64'(grant_p_s);
            tm_chipselect <= 1'b1;
            tm_write_n    <= 1'b0;
            tm_address    <= 4'd2;
            tm_writedata  <= grant_p_s[15:0];
            state_r       <= WR_P0;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        WR_P0: begin
          tm_chipselect <= 1'b1;
          tm_write_n    <= 1'b0;
          tm_address    <= 4'd3;
          tm_writedata  <= period_r[31:16];
          state_r       <= WR_P1;
        end
        WR_P1: begin
          tm_chipselect <= 1'b1;
          tm_write_n    <= 1'b0;
          tm_address    <= 4'd4;
          tm_writedata  <= period_r[47:32];
          state_r       <= WR_P2;
        end
        WR_P2: begin
          tm_chipselect <= 1'b1;
          tm_write_n    <= 1'b0;
          tm_address    <= 4'd5;
          tm_writedata  <= period_r[63:48];
          state_r       <= WR_P3;
        end
        WR_P3: begin
          tm_chipselect <= 1'b1;
          tm_write_n    <= 1'b0;
          tm_address    <= 4'd1;
          tm_writedata  <= CTRL_START;
          state_r       <= WR_CTRL;
        end
        WR_CTRL: begin
          state_r <= WAIT_IRQ;
        end
        WAIT_IRQ: begin
          // A dropped request takes priority over a simultaneous timeout
          if (!req[active_id]) begin
            tm_chipselect <= 1'b1;
            tm_write_n    <= 1'b0;
            tm_address    <= 4'd1;
            tm_writedata  <= CTRL_STOP;
            state_r       <= ABORT;
          end else if (tm_irq) begin
            tm_chipselect <= 1'b1;
            tm_address    <= 4'd0;
            state_r       <= RD_STAT;
          end else begin
            state_r <= WAIT_IRQ;
          end
        end
        RD_STAT: begin
          state_r <= RD_WAIT;
        end
        RD_WAIT: begin
          if (tm_readdata[0]) begin
            tm_chipselect <= 1'b1;
            tm_write_n    <= 1'b0;
            tm_address    <= 4'd0;
            tm_writedata  <= 16'h0000;
            state_r       <= CLR_STAT;
          end else begin
            state_r <= WAIT_IRQ;
          end
        end
        CLR_STAT: begin
          done[active_id] <= 1'b1;
          state_r         <= DONE;
        end
        DONE: begin
          rr_ptr_r <= next_ptr_s;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        ABORT: begin
          tm_chipselect <= 1'b1;
          tm_write_n    <= 1'b0;
          tm_address    <= 4'd0;
          tm_writedata  <= 16'h0000;
          state_r       <= ABORT_CLR;
        end
        ABORT_CLR: begin
          rr_ptr_r <= next_ptr_s;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_0_scheduler.sv
// Directed bench for timer_0_scheduler with a behavioural interval-timer model on the s1 port.
module tb_timer_0_scheduler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [127:0] delay;
  logic [3:0]   done;
  logic         busy;
  logic [1:0]   active_id;
  logic [3:0]   tm_address;
  logic         tm_chipselect;
  logic         tm_write_n;
  logic [15:0]  tm_writedata;
  logic [15:0]  tm_readdata;
  logic         tm_irq;
  logic         force_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [20:0] log_q[$];
  logic [3:0]  done_q[$];
  int          done_cyc_q[$];

  // timer model state
  logic [15:0] per_h[4];
  logic [63:0] cnt;
  logic        run, to, ito;

  timer_0_scheduler #(.N_REQ(4), .DELAY_W(32), .ID_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .delay(delay), .done(done), .busy(busy),
    .active_id(active_id), .tm_address(tm_address), .tm_chipselect(tm_chipselect),
    .tm_write_n(tm_write_n), .tm_writedata(tm_writedata), .tm_readdata(tm_readdata),
    .tm_irq(tm_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tm_irq = (to & ito) | force_irq;

  // Interval timer: counts period..0 after START, sets TO, one-shot; registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_h[0] <= 16'h0; per_h[1] <= 16'h0; per_h[2] <= 16'h0; per_h[3] <= 16'h0;
      cnt <= 64'd0; run <= 1'b0; to <= 1'b0; ito <= 1'b0; tm_readdata <= 16'h0;
    end else begin
      tm_readdata <= {14'd0, run, to};
      if (run) begin
        if (cnt == 64'd0) begin
          to  <= 1'b1;
          run <= 1'b0;
        end else begin
          cnt <= cnt - 64'd1;
        end
      end
      if (tm_chipselect && !tm_write_n) begin
        case (tm_address)
          4'd0: to <= 1'b0;
          4'd1: begin
            ito <= tm_writedata[0];
            if (tm_writedata[3]) run <= 1'b0;
            else if (tm_writedata[2]) begin
              run <= 1'b1;
              cnt <= {per_h[3], per_h[2], per_h[1], per_h[0]};
            end
          end
          4'd2: per_h[0] <= tm_writedata;
          4'd3: per_h[1] <= tm_writedata;
          4'd4: per_h[2] <= tm_writedata;
          4'd5: per_h[3] <= tm_writedata;
          default: ;
        endcase
      end
    end
  end

  // Bus and done monitor: entry = {is_read, address, writedata}
  always @(negedge clk) begin
    if (reset_n) begin
      if (tm_chipselect) log_q.push_back({tm_write_n, tm_address, tm_write_n ? 16'h0000 : tm_writedata});
      if (done != 4'b0000) begin
        done_q.push_back(done);
        done_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic wait_dones(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    log_q.delete();
    done_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'b0000; delay = '0; force_irq = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tm_chipselect, tm_write_n, tm_address, tm_writedata} !== {1'b1, 1'b1, 4'd0, 16'h0000} >> 1 | 22'h0 && 1'b0) begin end
    if ({tm_chipselect, tm_write_n, tm_address, tm_writedata} !== 22'h100000) begin
      errors++; $display("FAIL reset_bus got %h want 100000", {tm_chipselect, tm_write_n, tm_address, tm_writedata});
    end
    checks++;
    if ({done, busy, active_id} !== 7'b0000_1_00) begin
      errors++; $display("FAIL reset_state got %b want 0000100", {done, busy, active_id});
    end
    log_q.delete();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (log_q.size() != 1 || log_q[0] !== {1'b0, 4'd1, 16'h0008}) begin
      errors++; $display("FAIL reset_init_write got size %0d first %h want 1 entry 010008", log_q.size(), (log_q.size() > 0) ? log_q[0] : 21'h1fffff);
    end
    checks++;
    if (busy !== 1'b0 || done !== 4'b0000) begin
      errors++; $display("FAIL reset_idle got busy %b done %b want 0 0000", busy, done);
    end
  endtask

  task automatic test_single();
    bit ok;
    int t0;
    logic [20:0] exp[$];
    exp = '{{1'b0, 4'd2, 16'h0063}, {1'b0, 4'd3, 16'h0000}, {1'b0, 4'd4, 16'h0000}, {1'b0, 4'd5, 16'h0000},
            {1'b0, 4'd1, 16'h0005}, {1'b1, 4'd0, 16'h0000}, {1'b0, 4'd0, 16'h0000}};
    log_q.delete(); done_q.delete(); done_cyc_q.delete();
    @(negedge clk);
    delay[0 +: 32] = 32'd100;
    req = 4'b0001;
    t0 = cyc;
    wait_dones(1, 400, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout got no done want done[0]");
    end else begin
      checks++;
      if (done_q[0] !== 4'b0001) begin
        errors++; $display("FAIL single_done_ch got %b want 0001", done_q[0]);
      end
      checks++;
      if (done_cyc_q[0] - t0 != 110) begin
        errors++; $display("FAIL single_latency got %0d want 110", done_cyc_q[0] - t0);
      end
    end
    req = 4'b0000;
    wait_idle(20, ok);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++; $display("FAIL single_bus_len got %0d want %0d", log_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp[i]) begin
        errors++; $display("FAIL single_bus[%0d] got %h want %h", i, (i < log_q.size()) ? log_q[i] : 21'h1fffff, exp[i]);
      end
    end
    checks++;
    if (done_q.size() != 1) begin
      errors++; $display("FAIL single_pulses got %0d want 1", done_q.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int t0;
    logic [3:0] exp_order[6];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
    pulse_reset();
    for (int i = 0; i < 4; i++) delay[i*32 +: 32] = 32'd20;
    @(negedge clk);
    req = 4'b1111;
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        wait_idle(20, ok);
        req = 4'b1001;
      end
      wait_dones(k + 1, 200, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rr_timeout[%0d] got no done want %b", k, exp_order[k]);
        break;
      end
      checks++;
      if (done_q[k] !== exp_order[k]) begin
        errors++; $display("FAIL rr_order[%0d] got %b want %b", k, done_q[k], exp_order[k]);
      end
      req = req & ~done_q[k];
      if (k == 0) begin
        checks++;
        if (done_cyc_q[0] - t0 != 30) begin
          errors++; $display("FAIL rr_first_latency got %0d want 30", done_cyc_q[0] - t0);
        end
      end else if (k < 4) begin
        checks++;
        if (done_cyc_q[k] - done_cyc_q[k-1] != 31) begin
          errors++; $display("FAIL rr_spacing[%0d] got %0d want 31", k, done_cyc_q[k] - done_cyc_q[k-1]);
        end
      end
    end
    req = 4'b0000;
    wait_idle(20, ok);
  endtask

  task automatic test_period();
    bit ok;
    int t0;
    logic [20:0] exp[$];
    exp = '{{1'b0, 4'd2, 16'h2344}, {1'b0, 4'd3, 16'h0001}, {1'b0, 4'd4, 16'h0000}, {1'b0, 4'd5, 16'h0000},
            {1'b0, 4'd1, 16'h0005}, {1'b0, 4'd1, 16'h0008}, {1'b0, 4'd0, 16'h0000}};
    log_q.delete(); done_q.delete(); done_cyc_q.delete();
    @(negedge clk);
    delay[2*32 +: 32] = 32'h0001_2345;
    req = 4'b0100;
    repeat (8) @(negedge clk);
    req = 4'b0000;
    wait_idle(20, ok);
    #1;
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp[i]) begin
        errors++; $display("FAIL period_big[%0d] got %h want %h", i, (i < log_q.size()) ? log_q[i] : 21'h1fffff, exp[i]);
      end
    end
    // delay 1 and delay 0 both clamp to period 1
    for (int d = 1; d >= 0; d--) begin
      log_q.delete(); done_q.delete(); done_cyc_q.delete();
      @(negedge clk);
      delay[2*32 +: 32] = 32'(d);
      req = 4'b0100;
      t0 = cyc;
      wait_dones(1, 60, ok);
      checks++;
      if (!ok || done_q[0] !== 4'b0100 || done_cyc_q[0] - t0 != 12) begin
        errors++; $display("FAIL period_clamp_d%0d got done %b at %0d want 0100 at 12", d,
                           ok ? done_q[0] : 4'b0000, ok ? done_cyc_q[0] - t0 : -1);
      end
      checks++;
      if (log_q.size() < 2 || log_q[0] !== {1'b0, 4'd2, 16'h0001} || log_q[1] !== {1'b0, 4'd3, 16'h0000}) begin
        errors++; $display("FAIL period_clamp_p%0d got %h want 020001", d, (log_q.size() > 0) ? log_q[0] : 21'h1fffff);
      end
      req = 4'b0000;
      wait_idle(20, ok);
    end
  endtask

  task automatic test_abort();
    bit ok;
    logic [20:0] exp[$];
    exp = '{{1'b0, 4'd2, 16'h0031}, {1'b0, 4'd3, 16'h0000}, {1'b0, 4'd4, 16'h0000}, {1'b0, 4'd5, 16'h0000},
            {1'b0, 4'd1, 16'h0005}, {1'b0, 4'd1, 16'h0008}, {1'b0, 4'd0, 16'h0000}};
    log_q.delete(); done_q.delete(); done_cyc_q.delete();
    @(negedge clk);
    delay[1*32 +: 32] = 32'd50;
    req = 4'b0010;
    repeat (8) @(negedge clk);
    req = 4'b0000;
    wait_idle(20, ok);
    repeat (70) @(negedge clk);
    #1;
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++; $display("FAIL abort_bus_len got %0d want %0d", log_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp[i]) begin
        errors++; $display("FAIL abort_bus[%0d] got %h want %h", i, (i < log_q.size()) ? log_q[i] : 21'h1fffff, exp[i]);
      end
    end
    checks++;
    if (done_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done got %0d pulses busy %b want 0 pulses busy 0", done_q.size(), busy);
    end
    // pointer moved to 2, so with req 0 and 1 pending the wrap grants 0
    req = 4'b0011;
    repeat (3) @(negedge clk);
    checks++;
    if (active_id !== 2'd0) begin
      errors++; $display("FAIL abort_rr_next got %0d want 0", active_id);
    end
    req = 4'b0000;
    wait_idle(40, ok);
  endtask

  task automatic test_spurious_and_reset();
    bit ok;
    log_q.delete(); done_q.delete(); done_cyc_q.delete();
    @(negedge clk);
    delay[3*32 +: 32] = 32'd200;
    req = 4'b1000;
    repeat (10) @(negedge clk);
    log_q.delete();
    force_irq = 1'b1;
    @(negedge clk);
    force_irq = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (log_q.size() != 1 || log_q[0] !== {1'b1, 4'd0, 16'h0000}) begin
      errors++; $display("FAIL spurious_bus got size %0d first %h want 1 entry 100000", log_q.size(), (log_q.size() > 0) ? log_q[0] : 21'h1fffff);
    end
    checks++;
    if (done_q.size() != 0 || busy !== 1'b1 || active_id !== 2'd3) begin
      errors++; $display("FAIL spurious_state got pulses %0d busy %b id %0d want 0 1 3", done_q.size(), busy, active_id);
    end
    log_q.delete();
    reset_n = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (done !== 4'b0000 || busy !== 1'b1 || tm_chipselect !== 1'b0) begin
      errors++; $display("FAIL midreset_state got done %b busy %b cs %b want 0000 1 0", done, busy, tm_chipselect);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (log_q.size() != 1 || log_q[0] !== {1'b0, 4'd1, 16'h0008}) begin
      errors++; $display("FAIL midreset_stop got size %0d first %h want 1 entry 010008", log_q.size(), (log_q.size() > 0) ? log_q[0] : 21'h1fffff);
    end
    checks++;
    if (done_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_idle got pulses %0d busy %b want 0 0", done_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_period();
    test_abort();
    test_spurious_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
